// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys multiply/divide unit: funct codes,
// controller state encoding, iteration count and an operand-magnitude helper.
package minisys_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Absolute value for signed ops; 0x8000_0000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv32_if.sv
// Controller <-> multiply/divide unit bundle.
// Handshake: Start is a one-cycle request that is only taken while Busy is low;
// a request seen while Busy is high is dropped, never queued. Done pulses for
// exactly one cycle after HI/LO receive a new mult/div result.
interface multdiv32_if;
    import minisys_pkg::*;

    logic        Start;
    logic [5:0]  Function_opcode;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [31:0] Mdu_Result;
    mdu_state_e  dbg_state;

    modport master (
        output Start, Function_opcode, Read_data_1, Read_data_2,
        input  Busy, Done, Hi, Lo, Mdu_Result, dbg_state
    );

    modport slave (
        input  Start, Function_opcode, Read_data_1, Read_data_2,
        output Busy, Done, Hi, Lo, Mdu_Result, dbg_state
    );
endinterface

// File: rtl/multdiv32.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring, both on operand magnitudes,
// sharing one 64-bit working register and one iteration counter; signs are
// applied in the FIX state.
module multdiv32
    import minisys_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    multdiv32_if.slave   mdu
);

    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;        // multiplicand or divisor magnitude
    logic [31:0] dvd_raw_q, dvd_raw_d;  // dividend as presented, for divide by zero
    logic        is_div_q, is_div_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        dvz_q, dvz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_op, is_signed_op;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic [33:0] div_diff;
    logic [63:0] prod_neg;

    assign is_op        = (mdu.Function_opcode == FUNCT_MULT) || (mdu.Function_opcode == FUNCT_MULTU) ||
                          (mdu.Function_opcode == FUNCT_DIV)  || (mdu.Function_opcode == FUNCT_DIVU);
    assign is_signed_op = (mdu.Function_opcode == FUNCT_MULT) || (mdu.Function_opcode == FUNCT_DIV);
    assign mag_a        = mag32(mdu.Read_data_1, is_signed_op);
    assign mag_b        = mag32(mdu.Read_data_2, is_signed_op);

    // Multiply step: add multiplicand to the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole register right.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Divide step: shift the next dividend bit into the remainder, trial-subtract.
    assign div_rem  = {acc_q[63:32], acc_q[31]};
    assign div_diff = {1'b0, div_rem} - {2'b00, opnd_q};
    assign prod_neg = ~acc_q + 64'd1;

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        dvd_raw_d = dvd_raw_q;
        is_div_d  = is_div_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        dvz_d     = dvz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mdu.Start) begin
                    if (is_op) begin
                        state_d   = CALC;
                        cnt_d     = 5'd0;
                        is_div_d  = mdu.Function_opcode[1];
                        sign_a_d  = is_signed_op & mdu.Read_data_1[31];
                        sign_b_d  = is_signed_op & mdu.Read_data_2[31];
                        dvz_d     = (mdu.Read_data_2 == 32'd0);
                        dvd_raw_d = mdu.Read_data_1;
                        // mult: acc = {0, multiplier}, opnd = multiplicand
                        // div:  acc = {0, dividend},   opnd = divisor
                        opnd_d    = mdu.Function_opcode[1] ? mag_b : mag_a;
                        acc_d     = {32'd0, mdu.Function_opcode[1] ? mag_a : mag_b};
                    end else if (mdu.Function_opcode == FUNCT_MTHI) begin
                        hi_d = mdu.Read_data_1;
                    end else if (mdu.Function_opcode == FUNCT_MTLO) begin
                        lo_d = mdu.Read_data_1;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    else               acc_d = {div_rem[31:0],  acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER_COUNT - 1)) begin
                    state_d = FIX;
                    cnt_d   = 5'd0;
                end
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : acc_q;
                end else if (dvz_q) begin
                    hi_d = dvd_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    lo_d = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                    hi_d = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                end
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            dvd_raw_q <= 32'd0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            dvz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            dvd_raw_q <= dvd_raw_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            dvz_q     <= dvz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mdu.Busy       = busy_q;
    assign mdu.Done       = done_q;
    assign mdu.Hi         = hi_q;
    assign mdu.Lo         = lo_q;
    assign mdu.dbg_state  = state_q;
    assign mdu.Mdu_Result = (mdu.Function_opcode == FUNCT_MFHI) ? hi_q :
                            (mdu.Function_opcode == FUNCT_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_multdiv32.sv
// Directed bench for multdiv32: hand-computed HI/LO results, latency, Done
// pulse shape, Start-while-busy, register moves, reset mid-operation and
// same-cycle mfhi/mflo readback.
module tb_multdiv32;
    import minisys_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic busy_c1;
    logic busy_c33;

    multdiv32_if mif();

    multdiv32 dut (
        .clock (clk),
        .reset (rst),
        .mdu   (mif.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle Start; returns #1 after the accepting edge (E0).
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.Start           = 1'b1;
        mif.Function_opcode = f;
        mif.Read_data_1     = a;
        mif.Read_data_2     = b;
        @(posedge clk);
        #1 mif.Start = 1'b0;
    endtask

    // Step through cycles (sampled at negedge) until Done, with a cycle budget.
    task automatic wait_done(input int start_cyc, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = start_cyc;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1)  busy_c1  = mif.Busy;
            if (cyc == 33) busy_c33 = mif.Busy;
            if (mif.Done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no Done within %0d cycles, want Done in cycle 34", cyc);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        busy_c1  = 1'b0;
        busy_c33 = 1'b0;
        issue(f, a, b);
        wait_done(0, cyc);
        check_eq({tag, "/latency"}, 32'(cyc), 32'd34);
        check_eq({tag, "/busy_c1"}, 32'(busy_c1), 32'd1);
        check_eq({tag, "/busy_c33"}, 32'(busy_c33), 32'd1);
        check_eq({tag, "/busy_c34"}, 32'(mif.Busy), 32'd0);
        check_eq({tag, "/hi"}, mif.Hi, exp_hi);
        check_eq({tag, "/lo"}, mif.Lo, exp_lo);
        @(negedge clk);
        check_eq({tag, "/done_c35"}, 32'(mif.Done), 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        mif.Start = 1'b0;
        mif.Function_opcode = 6'h00;
        mif.Read_data_1 = 32'd0;
        mif.Read_data_2 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst/busy", 32'(mif.Busy), 32'd0);
        check_eq("rst/done", 32'(mif.Done), 32'd0);
        check_eq("rst/hi", mif.Hi, 32'd0);
        check_eq("rst/lo", mif.Lo, 32'd0);
        check_eq("rst/state", 32'(mif.dbg_state), 32'(IDLE));
        rst = 1'b0;

        run_op("mult_m1x2",   FUNCT_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_m1x2",  FUNCT_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_m7d2",    FUNCT_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2",    FUNCT_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_7d0",    FUNCT_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_m5d0",    FUNCT_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_min_dm1", FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("mult_minsq",  FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Start (div) pulsed in cycle 10 of a mult is ignored; mtlo in the Done cycle.
        issue(FUNCT_MULT, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        mif.Start           = 1'b1;
        mif.Function_opcode = FUNCT_DIV;
        mif.Read_data_1     = 32'd100;
        mif.Read_data_2     = 32'd3;
        @(posedge clk);
        #1 mif.Start = 1'b0;
        wait_done(10, cyc);
        check_eq("ign/latency", 32'(cyc), 32'd34);
        check_eq("ign/hi", mif.Hi, 32'd0);
        check_eq("ign/lo", mif.Lo, 32'd15);
        mif.Start           = 1'b1;
        mif.Function_opcode = FUNCT_MTLO;
        mif.Read_data_1     = 32'h0000_1234;
        @(posedge clk);
        #1 mif.Start = 1'b0;
        @(negedge clk);
        check_eq("mtlo/lo", mif.Lo, 32'h0000_1234);
        check_eq("mtlo/hi", mif.Hi, 32'd0);
        check_eq("mtlo/done", 32'(mif.Done), 32'd0);
        check_eq("mtlo/busy", 32'(mif.Busy), 32'd0);

        // mthi from idle
        issue(FUNCT_MTHI, 32'h0000_CAFE, 32'd0);
        @(negedge clk);
        check_eq("mthi/hi", mif.Hi, 32'h0000_CAFE);
        check_eq("mthi/busy", 32'(mif.Busy), 32'd0);

        // divu 100/7, then mfhi/mflo read in the Done cycle
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        wait_done(0, cyc);
        check_eq("divu100/latency", 32'(cyc), 32'd34);
        mif.Start           = 1'b1;
        mif.Function_opcode = FUNCT_MFLO;
        #1 check_eq("mflo/result", mif.Mdu_Result, 32'd14);
        mif.Function_opcode = 6'h20;
        #1 check_eq("other/result", mif.Mdu_Result, 32'd0);
        mif.Function_opcode = FUNCT_MFHI;
        #1 check_eq("mfhi/result", mif.Mdu_Result, 32'd2);
        @(posedge clk);
        #1 mif.Start = 1'b0;
        @(negedge clk);
        check_eq("mfhi/busy", 32'(mif.Busy), 32'd0);

        // reset in cycle 15 of a divu discards it
        issue(FUNCT_DIVU, 32'd1000, 32'd7);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid/busy", 32'(mif.Busy), 32'd0);
        check_eq("rstmid/hi", mif.Hi, 32'd0);
        check_eq("rstmid/lo", mif.Lo, 32'd0);
        check_eq("rstmid/state", 32'(mif.dbg_state), 32'(IDLE));
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.Done) dones++;
        end
        check_eq("rstmid/no_done", 32'(dones), 32'd0);
        run_op("mult_6x7", FUNCT_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
